// File: rtl/debounce_chamadas.sv
// Floor-call push-button debouncer: sync, tick-sampled debounce, press pulse, latched calls.
// Define DEBOUNCE_SIM_TICK_EN to debounce on every clock cycle (fast simulation).
module debounce_chamadas #(
  parameter int NUM_BOTOES   = 4,
  parameter int STABLE_TICKS = 2,
  parameter int ATIVO_BAIXO  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clock_debounce,
  input  logic [NUM_BOTOES-1:0] botoes_in,
  input  logic [NUM_BOTOES-1:0] limpar,
  output logic [NUM_BOTOES-1:0] botao_estavel,
  output logic [NUM_BOTOES-1:0] botao_pulso,
  output logic [NUM_BOTOES-1:0] chamada_pendente,
  output logic                  alguma_chamada
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [NUM_BOTOES-1:0] btn_raw;
  logic [NUM_BOTOES-1:0] btn_meta;
  logic [NUM_BOTOES-1:0] btn_sync;
  logic [NUM_BOTOES-1:0] stable;
  logic [NUM_BOTOES-1:0] stable_d;
  logic [NUM_BOTOES-1:0] pulso;
  logic [NUM_BOTOES-1:0] pendente;
  logic [CW-1:0]         cnt [NUM_BOTOES];
  logic                  tick;

  assign btn_raw = (ATIVO_BAIXO != 0) ? ~botoes_in : botoes_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

`ifdef DEBOUNCE_SIM_TICK_EN
  logic unused_clock_debounce;
  assign unused_clock_debounce = clock_debounce;
  assign tick = 1'b1;
`else
  // clock_debounce is data: synchronize, then detect its rising edge
  logic cd_meta;
  logic cd_sync;
  logic cd_dly;

  always_ff @(posedge clock) begin
    if (reset) begin
      cd_meta <= 1'b0;
      cd_sync <= 1'b0;
      cd_dly  <= 1'b0;
    end else begin
      cd_meta <= clock_debounce;
      cd_sync <= cd_meta;
      cd_dly  <= cd_sync;
    end
  end

  assign tick = cd_sync & ~cd_dly;
`endif

  // Count consecutive ticks that disagree with the stable level; any agreeing tick restarts.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < NUM_BOTOES; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < NUM_BOTOES; i++) begin
        if (btn_sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] + CW'(1) == CW'(STABLE_TICKS)) begin
          stable[i] <= btn_sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A new press sets the call even when the controller clears it in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_d <= '0;
      pulso    <= '0;
      pendente <= '0;
    end else begin
      stable_d <= stable;
      pulso    <= stable & ~stable_d;
      pendente <= pulso | (pendente & ~limpar);
    end
  end

  assign botao_estavel    = stable;
  assign botao_pulso      = pulso;
  assign chamada_pendente = pendente;
  assign alguma_chamada   = |pendente;

endmodule
